// File: rtl/duty_ramp_ctrl.sv
// Slew-rate limited duty command front end for a 16-clock PWM generator.
// Duty moves one LSB toward the target at PWM period boundaries; brake forces zero at once.
module duty_ramp_ctrl #(
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned MAX_DUTY     = 15
) (
  input  logic       clk_3125KHz,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_duty,
  output logic       cmd_ready,
  input  logic       brake,
  output logic [3:0] duty_cycle,
  output logic       ramp_busy,
  output logic       period_tick
);

  typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

  localparam logic [3:0] MaxDuty  = 4'(MAX_DUTY);
  localparam logic [7:0] LastStep = 8'(STEP_PERIODS - 1);

  state_e     state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic       tick_q, tick_d;
  logic [3:0] duty_q, duty_d;
  logic [3:0] target_q, target_d;
  logic [7:0] step_q, step_d;
  logic [3:0] cmd_target;
  logic [3:0] duty_step;
  logic       boundary;
  logic       accept;

  assign phase_d    = phase_q + 4'd1;
  // Registered so the pulse lines up with the cycle in which phase reads 15.
  assign tick_d     = (phase_q == 4'd14);
  assign boundary   = (phase_q == 4'd15);
  assign cmd_target = (cmd_duty > MaxDuty) ? MaxDuty : cmd_duty;
  assign cmd_ready  = (state_q == StIdle) && !brake;
  assign accept     = cmd_valid && cmd_ready;
  assign duty_step  = (state_q == StRampUp) ? duty_q + 4'd1 : duty_q - 4'd1;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    if (brake) begin
      state_d  = StIdle;
      duty_d   = 4'd0;
      target_d = 4'd0;
      step_d   = 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            target_d = cmd_target;
            if (cmd_target > duty_q) begin
              state_d = StRampUp;
              step_d  = 8'd0;
            end else if (cmd_target < duty_q) begin
              state_d = StRampDown;
              step_d  = 8'd0;
            end
          end
        end
        StRampUp, StRampDown: begin
          if (boundary) begin
            if (step_q == LastStep) begin
              step_d = 8'd0;
              duty_d = duty_step;
              if (duty_step == target_q) begin
                state_d = StIdle;
              end
            end else begin
              step_d = step_q + 8'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      state_q  <= StIdle;
      phase_q  <= 4'd0;
      tick_q   <= 1'b0;
      duty_q   <= 4'd0;
      target_q <= 4'd0;
      step_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
    end
  end

  assign duty_cycle  = duty_q;
  assign ramp_busy   = (state_q != StIdle);
  assign period_tick = tick_q;

endmodule

// File: doc/duty_ramp_ctrl.md
# duty_ramp_ctrl

Slew-rate limiter and command front end that drives the 4-bit `duty_cycle` input of the PWM generator. It accepts target duty commands over a valid/ready handshake and moves the applied duty toward the target one LSB at a time, every `STEP_PERIODS` PWM periods. Duty changes occur only at PWM period boundaries, so the PWM stage never sees a mid-period change. It also provides an immediate brake.

## Interface
- `STEP_PERIODS`, default 4: PWM periods (16 clocks each) between duty steps; legal range 1..256.
- `MAX_DUTY`, default 15: ceiling for accepted targets; legal range 0..15.

- `clk_3125KHz`  in  1: single clock, 3.125 MHz.
- `reset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: target command present.
- `cmd_duty`  in  4: requested target duty.
- `cmd_ready`  out  1: block can accept a command.
- `brake`  in  1: level; forces duty to 0.
- `duty_cycle`  out  4: registered duty, wired to the PWM generator.
- `ramp_busy`  out  1: high while applied duty differs from target.
- `period_tick`  out  1: one-cycle pulse on the last clock of each 16-clock PWM period.

## Operation
- **Phase counter.** 4-bit `phase` runs 0..15 and wraps 15→0. Reset sets it to 0.
  - `period_tick` = (`phase`==15), registered; it pulses in the cycle in which `phase` is 15.
  - A "boundary" is the clock edge at which `phase` goes 15→0.
- **State machine.** States are IDLE, RAMP_UP and RAMP_DOWN. `cmd_ready` = (state==IDLE) && !`brake`.
- **Command accept.** A command is accepted on an edge with `cmd_valid` && `cmd_ready`.
  - Target = min(`cmd_duty`, `MAX_DUTY`).
  - If target == `duty_cycle`: stay in IDLE and leave the step counter untouched.
  - If target > `duty_cycle`: go to RAMP_UP. If target < `duty_cycle`: go to RAMP_DOWN.
  - In both ramp states, the 8-bit step counter `step_cnt` is cleared to 0 on entry.
- **Commands outside IDLE.** Commands presented in RAMP_UP/RAMP_DOWN are not accepted (`cmd_ready`=0). The source holds `cmd_valid`/`cmd_duty` until it sees ready.
- **Ramping, at each boundary in RAMP_UP or RAMP_DOWN.**
  - If `step_cnt` == `STEP_PERIODS`-1: `duty_cycle` moves ±1 and `step_cnt` is set to 0.
  - Otherwise: `step_cnt` increments.
  - If the new `duty_cycle` equals the target, the state returns to IDLE on that same edge.
- **Arithmetic.** `duty_cycle` never wraps. RAMP_UP stops at the target (≤ `MAX_DUTY` ≤ 15), and RAMP_DOWN stops at the target (≥ 0).
- **Brake.** Brake has priority over everything except reset. On any edge with `brake`=1:
  - `duty_cycle` ← 0, target ← 0, state ← IDLE, `step_cnt` ← 0.
  - This does not wait for a boundary.
  - `phase` keeps running.
  - While `brake` is high, `cmd_ready`=0 and no command is accepted.
- **`ramp_busy`** = (state != IDLE).
- **Reset** (at any point, including mid-ramp): `duty_cycle`=0, target=0, state=IDLE, `phase`=0, `step_cnt`=0, `period_tick`=0. After reset, `ramp_busy`=0, and `cmd_ready`=1 whenever `brake`=0.

## Timing
- **Reset exit.** In the first cycle after `reset` deasserts, `phase`=0. `period_tick` is high in cycles 15, 31, 47, …, and boundaries are the edges that end those cycles.
- **Command latency.** Accept → first duty step takes `STEP_PERIODS` boundaries. With phase offset at accept time, that is 16·`STEP_PERIODS`-15 to 16·`STEP_PERIODS` clocks.
  - Each later step follows exactly 16·`STEP_PERIODS` clocks after the previous one.
- **Ramp completion.** `ramp_busy` falls, and `cmd_ready` rises, in the cycle after the final step edge.
- **Brake latency.** `duty_cycle` reads 0 in the cycle after `brake` is sampled high.
- **Simultaneous events.** If a boundary coincides with `brake`, brake wins. If `cmd_valid` coincides with `brake`, the command is not accepted.
- **Full ramp.** A 0→15 ramp with `STEP_PERIODS`=4 takes 60 boundaries, which is 960 clocks when the command is accepted at `phase`=0.

## Test plan
- **Reset defaults.** Hold `reset` 3 cycles, then release.
  - `duty_cycle`=0, `ramp_busy`=0, `cmd_ready`=1.
  - `period_tick` pulses in cycles 15, 31, 47.
- **Ramp up.** Accept `cmd_duty`=5 in cycle 0 after reset.
  - `duty_cycle` steps 1,2,3,4,5 at the edges ending cycles 63, 127, 191, 255, 319.
  - `ramp_busy` is 0 and `cmd_ready` is 1 from cycle 320.
- **Clamp and ramp down.** With `MAX_DUTY`=10, accept 15 at duty 0: the ramp stops at 10. Then accept 7: duty goes 10→9→8→7, one step every 64 clocks.
- **No-op and back-pressure.**
  - Accept `cmd_duty` equal to the current duty: `ramp_busy` stays 0.
  - Present a command mid-ramp with `cmd_valid` held: it is accepted only after `ramp_busy` falls, and then ramps from there.
- **Brake mid-ramp.** Pulse `brake` at duty 6 during RAMP_UP to 12, at `phase`=7.
  - Next cycle: `duty_cycle`=0 and `ramp_busy`=0.
  - `cmd_valid` held during brake is not accepted.
  - `phase` continues without disturbance.
- **Reset mid-ramp and `STEP_PERIODS`=1.**
  - Assert `reset` at duty 4: all outputs return to reset values the next cycle.
  - With `STEP_PERIODS`=1, a 0→3 ramp steps at every boundary (cycles 15, 31, 47).
